// File: rtl/bpred_pkg.sv
// Shared types and constants for the next-fetch-address predictor.
package bpred_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned OP_W  = 6;
   localparam int unsigned CTR_W = 2;

   localparam logic [OP_W-1:0] OP_BEQ   = 6'h26;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h1E;
   localparam logic [OP_W-1:0] OP_BGE   = 6'h0E;
   localparam logic [OP_W-1:0] OP_BLT   = 6'h16;
   localparam logic [OP_W-1:0] OP_BGEU  = 6'h2E;
   localparam logic [OP_W-1:0] OP_BLTU  = 6'h36;
   localparam logic [OP_W-1:0] OP_BR    = 6'h06;
   localparam logic [OP_W-1:0] OP_CALL  = 6'h00;
   localparam logic [OP_W-1:0] OP_JMPI  = 6'h01;
   localparam logic [OP_W-1:0] OP_RTYPE = 6'h3A;

   localparam logic [OP_W-1:0] OPX_CALLR = 6'h1D;
   localparam logic [OP_W-1:0] OPX_JMP   = 6'h0D;
   localparam logic [OP_W-1:0] OPX_RET   = 6'h05;

   typedef enum logic [2:0] {
      COND,
      BR,
      DIRECT,
      INDIRECT,
      OTHER
   } insn_class_e;

   typedef logic [CTR_W-1:0] ctr_t;

   localparam ctr_t CTR_RESET = 2'd1;
   localparam ctr_t CTR_MAX   = 2'd3;
   localparam ctr_t CTR_MIN   = 2'd0;

   typedef struct packed {
      insn_class_e      cls;
      logic [XLEN-1:0]  imm16_sext;
      logic [25:0]      imm26;
   } decode_t;

   // Saturating 2-bit counter update.
   function automatic ctr_t ctr_train(input ctr_t c, input logic t);
      ctr_t r;
      r = c;
      if (t && (c != CTR_MAX)) begin
         r = c + 2'd1;
      end else if (!t && (c != CTR_MIN)) begin
         r = c - 2'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bpred_decode.sv
// Classifies the fetched instruction and extracts its branch immediates.
module bpred_decode
   import bpred_pkg::*;
(
   input  logic [XLEN-1:0] insn_i,
   output decode_t         dec_c_o
);

   logic [OP_W-1:0] op;
   logic [OP_W-1:0] opx;

   assign op  = insn_i[5:0];
   assign opx = insn_i[16:11];

   always_comb begin
      dec_c_o            = '0;
      dec_c_o.cls        = OTHER;
      dec_c_o.imm16_sext = {{16{insn_i[21]}}, insn_i[21:6]};
      dec_c_o.imm26      = insn_i[31:6];
      case (op)
         OP_BEQ, OP_BNE, OP_BGE, OP_BLT, OP_BGEU, OP_BLTU: dec_c_o.cls = COND;
         OP_BR:                                            dec_c_o.cls = BR;
         OP_CALL, OP_JMPI:                                 dec_c_o.cls = DIRECT;
         OP_RTYPE: begin
            if ((opx == OPX_CALLR) || (opx == OPX_JMP) || (opx == OPX_RET)) begin
               dec_c_o.cls = INDIRECT;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bpred_top.sv
// Next-fetch-address predictor: PC register, direction counters and tagless BTB.
// Define BPRED_BHT_EN for dynamic 2-bit counters; otherwise backward-taken static rule.
module bpred_top
   import bpred_pkg::*;
#(
   parameter int unsigned BHT_IDX_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] insn,
   input  logic            wren,
   input  logic [XLEN-1:0] w_data,
   input  logic [XLEN-1:0] w_addr,
   input  logic            taken,
   output logic [XLEN-1:0] bTarget
);

   localparam int unsigned ENTRIES = 1 << BHT_IDX_W;

   logic [XLEN-1:0]      pc_q;
   logic [BHT_IDX_W-1:0] rd_idx;
   logic [BHT_IDX_W-1:0] wr_idx;
   decode_t              dec;

   logic [ENTRIES-1:0]   btb_valid_q;
   logic [XLEN-1:0]      btb_tgt_q [ENTRIES];

   logic                 cond_taken;
   logic [XLEN-1:0]      pc_plus4;
   logic [XLEN-1:0]      rel_tgt;
   logic [XLEN-1:0]      abs_tgt;
   logic [XLEN-1:0]      next_pc_c;

   logic                 unused_waddr;

   assign rd_idx       = pc_q[BHT_IDX_W+1:2];
   assign wr_idx       = w_addr[BHT_IDX_W+1:2];
   assign unused_waddr = ^{w_addr[XLEN-1:BHT_IDX_W+2], w_addr[1:0]};

   bpred_decode u_decode (
      .insn_i  (insn),
      .dec_c_o (dec)
   );

`ifdef BPRED_BHT_EN
   ctr_t [ENTRIES-1:0] ctr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ctr_q <= {ENTRIES{CTR_RESET}};
      end else if (dec.cls == COND) begin
         ctr_q[rd_idx] <= ctr_train(ctr_q[rd_idx], taken);
      end
   end

   assign cond_taken = ctr_q[rd_idx][CTR_W-1];
`else
   logic unused_taken;

   assign unused_taken = taken;
   // Static rule: backward branches predicted taken.
   assign cond_taken   = dec.imm16_sext[XLEN-1];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         btb_valid_q <= '0;
      end else if (wren) begin
         btb_valid_q[wr_idx] <= 1'b1;
      end
   end

   // Target storage is deliberately not reset; the valid bits gate its use.
   always_ff @(posedge clk) begin
      if (wren && !reset) begin
         btb_tgt_q[wr_idx] <= w_data;
      end
   end

   always_comb begin
      pc_plus4  = pc_q + 32'd4;
      rel_tgt   = pc_plus4 + dec.imm16_sext;
      abs_tgt   = {pc_q[XLEN-1:28], dec.imm26, 2'b00};
      next_pc_c = pc_plus4;
      case (dec.cls)
         COND:     next_pc_c = cond_taken ? rel_tgt : pc_plus4;
         BR:       next_pc_c = rel_tgt;
         DIRECT:   next_pc_c = abs_tgt;
         INDIRECT: next_pc_c = btb_valid_q[rd_idx] ? btb_tgt_q[rd_idx] : pc_plus4;
         default:  next_pc_c = pc_plus4;
      endcase
      if (reset) begin
         next_pc_c = '0;
      end
   end

   assign bTarget = next_pc_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= next_pc_c;
      end
   end

endmodule

// File: tb/tb_bpred_top.sv
// Directed plus randomized check of bpred_top against a behavioural predictor model.
module tb_bpred_top;

`ifdef BPRED_BHT_EN
   localparam bit BHT = 1'b1;
`else
   localparam bit BHT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] insn;
   logic        wren;
   logic [31:0] w_data;
   logic [31:0] w_addr;
   logic        taken;
   logic [31:0] bTarget;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   logic [31:0] m_pc;
   int          m_cnt [256];
   bit          m_val [256];
   logic [31:0] m_tgt [256];

   logic [5:0]  cond_ops [6] = '{6'h26, 6'h1E, 6'h0E, 6'h16, 6'h2E, 6'h36};
   logic [5:0]  ind_opx  [3] = '{6'h1D, 6'h0D, 6'h05};

   bpred_top #(.BHT_IDX_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .insn    (insn),
      .wren    (wren),
      .w_data  (w_data),
      .w_addr  (w_addr),
      .taken   (taken),
      .bTarget (bTarget)
   );

   always #5 clk = ~clk;

   function automatic bit is_cond(input logic [31:0] in);
      return in[5:0] inside {6'h26, 6'h1E, 6'h0E, 6'h16, 6'h2E, 6'h36};
   endfunction

   function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] in);
      logic [5:0]  op;
      logic [5:0]  opx;
      logic [31:0] simm;
      int          idx;
      bit          tk;
      op   = in[5:0];
      opx  = in[16:11];
      simm = {{16{in[21]}}, in[21:6]};
      idx  = int'(pc[9:2]);
      if (is_cond(in)) begin
         tk = BHT ? (m_cnt[idx] >= 2) : in[21];
         return tk ? (pc + 32'd4 + simm) : (pc + 32'd4);
      end
      if (op == 6'h06) return pc + 32'd4 + simm;
      if (op == 6'h00 || op == 6'h01) return {pc[31:28], in[31:6], 2'b00};
      if (op == 6'h3A && (opx inside {6'h1D, 6'h0D, 6'h05}))
         return m_val[idx] ? m_tgt[idx] : (pc + 32'd4);
      return pc + 32'd4;
   endfunction

   task automatic step(input logic [31:0] in, input bit tk, input bit we,
                       input logic [31:0] wa, input logic [31:0] wd, input bit rs,
                       input string tag, input bit has_c, input logic [31:0] exp_c);
      logic [31:0] expv;
      int          idx;
      insn   = in;
      taken  = tk;
      wren   = we;
      w_addr = wa;
      w_data = wd;
      reset  = rs;
      @(negedge clk);
      expv = rs ? 32'h0 : predict(m_pc, in);
      total++;
      assert (bTarget === expv) else begin
         bad++;
         $error("FAIL %s: bTarget=%h expected %h (pc=%h insn=%h)", tag, bTarget, expv, m_pc, in);
      end
      if (has_c) begin
         total++;
         assert (bTarget === exp_c) else begin
            bad++;
            $error("FAIL %s_const: bTarget=%h expected %h", tag, bTarget, exp_c);
         end
      end
      @(posedge clk);
      if (rs) begin
         m_pc = 32'h0;
         for (int i = 0; i < 256; i++) begin
            m_cnt[i] = 1;
            m_val[i] = 1'b0;
         end
      end else begin
         idx = int'(m_pc[9:2]);
         if (BHT && is_cond(in)) begin
            if (tk && m_cnt[idx] < 3) m_cnt[idx] = m_cnt[idx] + 1;
            if (!tk && m_cnt[idx] > 0) m_cnt[idx] = m_cnt[idx] - 1;
         end
         if (we) begin
            m_tgt[int'(wa[9:2])] = wd;
            m_val[int'(wa[9:2])] = 1'b1;
         end
         m_pc = expv;
      end
      #1;
   endtask

   task automatic go(input logic [31:0] in, input bit tk, input string tag);
      step(in, tk, 1'b0, 32'h0, 32'h0, 1'b0, tag, 1'b0, 32'h0);
   endtask

   task automatic go_x(input logic [31:0] in, input bit tk, input string tag, input logic [31:0] e);
      step(in, tk, 1'b0, 32'h0, 32'h0, 1'b0, tag, 1'b1, e);
   endtask

   task automatic rst();
      step(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "reset", 1'b1, 32'h0);
   endtask

   localparam logic [31:0] CALL20 = 32'h0000_0200;
   localparam logic [31:0] BNE_M8 = 32'h003F_FE1E;
   localparam logic [31:0] CALLR  = 32'h083E_E83A;

   initial begin
      logic [31:0] in;
      logic [31:0] hi;
      logic [15:0] imm;
      int          r;
      m_pc = 32'h0;

      // Counter training on beq at PC 0
      rst();
      go_x(32'h0000_0126, 1'b1, "beq_cnt1", 32'h4);
      go_x(32'h0000_0000, 1'b0, "call_to0", 32'h0);
      go_x(32'h0000_0126, 1'b1, "beq_cnt2", BHT ? 32'h8 : 32'h4);

      // Direct call and BTB hit/miss
      rst();
      go_x(32'h0000_0080, 1'b0, "call8", 32'h8);
      step(32'h0000_0080, 1'b0, 1'b1, 32'h8, 32'h40, 1'b0, "btb_wr", 1'b1, 32'h8);
      go_x(CALLR, 1'b0, "callr_hit", 32'h40);
      rst();
      go_x(32'h0000_0080, 1'b0, "call8b", 32'h8);
      go_x(CALLR, 1'b0, "callr_miss", 32'hC);

      // Backward bne saturating up then down
      for (int k = 0; k < 3; k++) begin
         go(CALL20, 1'b0, "to20");
         go(BNE_M8, 1'b1, "bne_up");
      end
      go(CALL20, 1'b0, "to20");
      go_x(BNE_M8, 1'b1, "bne_c3", 32'h1C);
      for (int k = 0; k < 4; k++) begin
         go(CALL20, 1'b0, "to20");
         go(BNE_M8, 1'b0, "bne_dn");
      end
      go(CALL20, 1'b0, "to20");
      go_x(BNE_M8, 1'b0, "bne_c0", BHT ? 32'h24 : 32'h1C);

      // Unknown opcode and ret miss
      go(32'h0000_0100, 1'b0, "to10");
      go_x(32'h0000_003F, 1'b0, "unknown", 32'h14);
      go_x(32'h0000_283A, 1'b0, "ret_miss", 32'h18);

      // Reset overriding a write and a training update
      for (int k = 0; k < 2; k++) begin
         go(CALL20, 1'b0, "to20");
         go(BNE_M8, 1'b1, "bne_tr");
      end
      go(CALL20, 1'b0, "to20");
      step(BNE_M8, 1'b1, 1'b1, 32'h20, 32'h99, 1'b1, "rst_mid", 1'b1, 32'h0);
      go_x(32'h0000_003F, 1'b0, "pc_zero", 32'h4);
      go(CALL20, 1'b0, "to20");
      go_x(32'h0000_683A, 1'b0, "jmp_inval", 32'h24);
      go(CALL20, 1'b0, "to20");
      go_x(BNE_M8, 1'b0, "ctr_back1", BHT ? 32'h24 : 32'h1C);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r   = int'($urandom_range(0, 9));
         hi  = $urandom;
         imm = 16'((int'($urandom_range(0, 63)) - 32) * 4);
         case (r)
            0, 1, 2: in = {hi[31:22], imm, cond_ops[$urandom_range(0, 5)]};
            3:       in = {hi[31:22], imm, 6'h06};
            5, 6: begin
               in        = hi;
               in[5:0]   = 6'h3A;
               in[16:11] = ind_opx[$urandom_range(0, 2)];
            end
            7:       in = hi;
            default: in = {26'($urandom_range(0, 255)), 5'd0, 1'($urandom_range(0, 1))};
         endcase
         step(in, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom, $urandom,
              ($urandom_range(0, 149) == 0), "random", 1'b0, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
